fifo_read_serializer: RTL and testbench
=======================================

Name: fifo_read_serializer

Overview:
Read-side consumer for the async FIFO, running entirely in the read clock domain. It watches r_empty, pops one word at a time with r_en and captures rdata. Each word is shifted out MSB-first on a 1-bit valid/ready serial interface, with a last flag on the final bit. It is the drain end of the FIFO path, sitting between fifo_async_top_module's read port and a downstream bit consumer.

Parameters:
MEMORY_WIDTH, 4, FIFO word width; also the number of serial bits per word.
CNT_WIDTH, 8, width of the popped-word counter.

Ports:
r_clk  input  1  read-domain clock, rising edge.
r_rst  input  1  synchronous, active-high reset.
enable  input  1  permits new FIFO pops; sampled in IDLE only.
r_empty  input  1  FIFO empty flag, already synchronous to r_clk.
rdata  input  MEMORY_WIDTH  FIFO read data, valid on the cycle after r_en.
r_en  output  1  FIFO pop strobe, one r_clk cycle per word.
ser_valid  output  1  serial bit valid.
ser_data  output  1  current serial bit.
ser_last  output  1  high with ser_valid on the last bit (LSB) of a word.
ser_ready  input  1  downstream accepts the bit when ser_valid && ser_ready.
busy  output  1  high in any state other than IDLE.
word_count  output  CNT_WIDTH  number of words fully shifted out; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset: r_rst is sampled on the r_clk rising edge. The state, shift register, bit counter and word_count clear to 0, and all outputs are 0.
- Reset mid-operation: a word already popped but not yet fully shifted is discarded; no recovery.
- FSM states: IDLE, REQ, CAPT, SHIFT. All outputs decode from registers; there is no combinational path from inputs to outputs.
- IDLE: if enable==1 and r_empty==0 at an edge, go to REQ. Otherwise stay in IDLE.
- REQ: r_en=1 for exactly this one cycle, then unconditionally go to CAPT.
- CAPT: at the CAPT edge, shift register <= rdata and bit counter <= MEMORY_WIDTH-1; go to SHIFT. r_en=0.
- SHIFT: ser_valid=1, ser_data=shreg[MEMORY_WIDTH-1], ser_last=(bit counter==0).
  - On a handshake with bit counter >0: shift left by 1 (zero fill) and decrement the counter.
  - On a handshake with bit counter ==0: increment word_count and go to IDLE.
  - ser_ready low: hold state; ser_data and ser_last are stable. ser_valid never drops without a handshake.
- Latency: r_empty low sampled in IDLE at edge t; r_en is high during cycle t..t+1; the first bit is valid after edge t+2. Minimum per word is MEMORY_WIDTH+3 cycles, including one mandatory IDLE cycle between words.
- enable deasserted mid-word: the current word completes normally and no new pop is issued.
- r_en is only issued after r_empty was sampled low, so the block never pops an empty FIFO. At most one word is in flight; no prefetch.
- Simultaneous events: r_rst has priority over everything. A last-bit handshake and a word_count wrap in the same cycle are legal: the counter goes 255→0 with CNT_WIDTH=8.

Decomposition:
- Shared package holds:
  - the state encoding localparams, 2-bit: IDLE=0, REQ=1, CAPT=2, SHIFT=3;
  - the bit-counter width, clog2(MEMORY_WIDTH).
- No sub-module: counter, shift register and FSM stay in one module, 120–200 lines.

Test Plan:
1. Single word: FIFO holds 4'b1010, enable=1, ser_ready=1 -> one r_en pulse; ser_data 1,0,1,0 on 4 consecutive cycles; ser_last only on the 4th; word_count=1; then IDLE with busy=0.
2. Five words 1..5, written through the FIFO into depth 4 with the write side stalling on w_full -> serial stream 0001,0010,0011,0100,0101 in order; exactly 5 r_en pulses; word_count=5; no r_en while r_empty=1.
3. Backpressure: word 4'b0110, ser_ready held low 3 cycles on the 2nd bit -> ser_valid stays 1 and ser_data stays 1 for those cycles; total stream still 0,1,1,0; no bit is duplicated or dropped.
4. Reset mid-shift: r_rst=1 for one edge after the 2nd bit of 4'b1100 -> next cycle all outputs 0 and state IDLE; the next FIFO word shifts out cleanly from its MSB.
5. enable dropped during SHIFT of word A, with word B queued -> A completes; no r_en while enable=0; B starts exactly 1 cycle after enable returns to 1.
6. Counter wrap: CNT_WIDTH=2, 5 words -> word_count goes 1,2,3,0,1.

Source files
------------

// File: rtl/fifo_read_serializer_pkg.sv
// Shared definitions for the FIFO read-side serializer: state encoding and
// the helper that sizes the per-word bit counter.
package fifo_read_serializer_pkg;

  // Consumer FSM: wait for data, pop, capture, then shift bits out.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_CAPT  = 2'd2,
    ST_SHIFT = 2'd3
  } state_e;

  localparam int DEF_MEMORY_WIDTH = 4;
  localparam int DEF_CNT_WIDTH    = 8;

  // Bit-counter width: clog2 of the word width, with a floor of one bit so
  // that 1-bit words still get a legal vector.
  function automatic int bcnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/fifo_read_serializer.sv
// Drains the async FIFO read port one word at a time and emits each word
// MSB-first on a 1-bit valid/ready stream, flagging the LSB with ser_last.
// Every output decodes from flops; inputs only steer next-state logic.
module fifo_read_serializer
  import fifo_read_serializer_pkg::*;
#(
  parameter int MEMORY_WIDTH = DEF_MEMORY_WIDTH,
  parameter int CNT_WIDTH    = DEF_CNT_WIDTH
) (
  input  logic                    r_clk,
  input  logic                    r_rst,
  input  logic                    enable,
  input  logic                    r_empty,
  input  logic [MEMORY_WIDTH-1:0] rdata,
  output logic                    r_en,
  output logic                    ser_valid,
  output logic                    ser_data,
  output logic                    ser_last,
  input  logic                    ser_ready,
  output logic                    busy,
  output logic [CNT_WIDTH-1:0]    word_count
);

  localparam int BW = bcnt_width(MEMORY_WIDTH);
  localparam logic [BW-1:0] BIT_TOP = BW'(MEMORY_WIDTH - 1);

  state_e                  state_q, state_d;
  logic [MEMORY_WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]           bcnt_q,  bcnt_d;
  logic [CNT_WIDTH-1:0]    wcnt_q,  wcnt_d;

  logic hs;        // a bit is accepted downstream at the coming edge
  logic last_bit;  // the bit on the wire is the LSB of the word

  assign hs       = (state_q == ST_SHIFT) && ser_ready;
  assign last_bit = (bcnt_q == '0);

  // State and datapath registers; reset drops any partially shifted word.
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      bcnt_q  <= '0;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      bcnt_q  <= bcnt_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next-state: one pop per word, never while empty, no prefetch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (enable && !r_empty) state_d = ST_REQ;
      ST_REQ:   state_d = ST_CAPT;
      ST_CAPT:  state_d = ST_SHIFT;
      ST_SHIFT: if (hs && last_bit) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Shift register, bit counter and completed-word counter updates.
  always_comb begin
    shreg_d = shreg_q;
    bcnt_d  = bcnt_q;
    wcnt_d  = wcnt_q;
    if (state_q == ST_CAPT) begin
      shreg_d = rdata;
      bcnt_d  = BIT_TOP;
    end else if (hs) begin
      if (last_bit) begin
        // Free-running count; wraps naturally at 2^CNT_WIDTH.
        wcnt_d = wcnt_q + CNT_WIDTH'(1);
      end else begin
        shreg_d = shreg_q << 1;
        bcnt_d  = bcnt_q - BW'(1);
      end
    end
  end

  // Output decode, purely from registered state.
  always_comb begin
    r_en       = (state_q == ST_REQ);
    ser_valid  = (state_q == ST_SHIFT);
    // Gated so the leftover shifted LSB never shows on the wire while idle.
    ser_data   = (state_q == ST_SHIFT) && shreg_q[MEMORY_WIDTH-1];
    ser_last   = (state_q == ST_SHIFT) && last_bit;
    busy       = (state_q != ST_IDLE);
    word_count = wcnt_q;
  end

endmodule

// File: tb/tb_fifo_read_serializer.sv
// Bench for fifo_read_serializer: a depth-4 FIFO model feeds the DUT and the
// expected serial stream is the FIFO word order, MSB first per word.
module tb_fifo_read_serializer;

  localparam int MW = 4;
  localparam int CW = 8;

  logic          r_clk = 1'b0;
  logic          r_rst = 1'b1;
  logic          enable = 1'b0;
  logic          r_empty = 1'b1;
  logic [MW-1:0] rdata = '0;
  logic          ser_ready = 1'b0;
  logic          r_en, ser_valid, ser_data, ser_last, busy;
  logic [CW-1:0] word_count;

  fifo_read_serializer #(.MEMORY_WIDTH(MW), .CNT_WIDTH(CW)) dut (
    .r_clk      (r_clk),
    .r_rst      (r_rst),
    .enable     (enable),
    .r_empty    (r_empty),
    .rdata      (rdata),
    .r_en       (r_en),
    .ser_valid  (ser_valid),
    .ser_data   (ser_data),
    .ser_last   (ser_last),
    .ser_ready  (ser_ready),
    .busy       (busy),
    .word_count (word_count)
  );

  always #5 r_clk = ~r_clk;

  int total = 0;
  int bad   = 0;

  logic [MW-1:0] fifo[$];
  logic [MW-1:0] pending[$];
  bit            exp_bits[$];
  int            exp_wc = 0;
  int            cyc = 0;
  int            ren_cnt = 0, ren_cyc = -1, val_cyc = -1, last_cyc = -1;
  bit            pv = 0, pr = 0, pd = 0, pl = 0, en_prev = 0;
  bit            rnd_rdy = 0, rnd_en = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, account this cycle's handshake and pop, then
  // advance and check the registered outputs of the new cycle.
  task automatic step(input bit rst, input bit en, input bit rdy);
    bit b;
    r_rst = rst; enable = en; ser_ready = rdy;
    if (!rst && ser_valid && rdy) begin
      if (exp_bits.size() == 0) chk("stray_bit", 1, 0);
      else begin
        b = exp_bits.pop_front();
        chk("ser_data", ser_data, b);
        chk("ser_last", ser_last, exp_bits.size() == 0);
        if (exp_bits.size() == 0) begin
          exp_wc   = (exp_wc + 1) % 256;
          last_cyc = cyc;
        end
      end
    end
    if (ser_valid && val_cyc < 0) val_cyc = cyc;
    if (r_en) begin
      ren_cnt++;
      ren_cyc = cyc;
      chk("ren_while_disabled", en_prev, 1);
      if (fifo.size() == 0) chk("ren_on_empty", 1, 0);
      else begin
        rdata = fifo.pop_front();
        if (!rst) for (int i = MW - 1; i >= 0; i--) exp_bits.push_back(rdata[i]);
      end
    end
    if (fifo.size() < 4 && pending.size() > 0) fifo.push_back(pending.pop_front());
    r_empty = (fifo.size() == 0);
    pv = ser_valid; pr = rdy; pd = ser_data; pl = ser_last; en_prev = en;
    @(posedge r_clk); #1; cyc++;
    if (rst) begin
      chk("rst_r_en", r_en, 0);
      chk("rst_ser_valid", ser_valid, 0);
      chk("rst_ser_data", ser_data, 0);
      chk("rst_ser_last", ser_last, 0);
      chk("rst_busy", busy, 0);
      chk("rst_word_count", word_count, 0);
      exp_wc = 0;
      exp_bits.delete();
    end else begin
      chk("word_count", word_count, exp_wc);
      if (pv && !pr) begin
        chk("hold_valid", ser_valid, 1);
        chk("hold_data", ser_data, pd);
        chk("hold_last", ser_last, pl);
      end
    end
  endtask

  task automatic run_idle(input int budget);
    int n;
    n = 0;
    while ((fifo.size() > 0 || pending.size() > 0 || exp_bits.size() > 0 || busy) && n < budget) begin
      step(0, rnd_en ? ($urandom % 4 != 0) : 1'b1, rnd_rdy ? 1'($urandom % 2) : 1'b1);
      n++;
    end
    if (n >= budget) chk("drain_timeout", 0, 1);
  endtask

  task automatic wait_valid(input bit en);
    int n;
    n = 0;
    while (!ser_valid && n < 20) begin step(0, en, 1); n++; end
    if (!ser_valid) chk("wait_valid_timeout", 0, 1);
  endtask

  initial begin
    int c0, r0;
    // reset
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    chk("idle_busy", busy, 0);

    // single word 1010, latency and timing
    pending.push_back(4'b1010);
    val_cyc = -1;
    c0 = cyc;
    step(0, 1, 1);
    run_idle(50);
    chk("t1_ren_cycle", ren_cyc, c0 + 1);
    chk("t1_first_valid", val_cyc, c0 + 3);
    chk("t1_last_cycle", last_cyc, c0 + 6);
    chk("t1_ren_count", ren_cnt, 1);
    chk("t1_word_count", word_count, 1);
    chk("t1_busy", busy, 0);

    // five words through a depth-4 FIFO with write stalls
    r0 = ren_cnt;
    for (int w = 1; w <= 5; w++) pending.push_back(MW'(w));
    run_idle(200);
    chk("t2_ren_count", ren_cnt - r0, 5);
    chk("t2_word_count", word_count, 6);

    // backpressure on the 2nd bit of 0110
    pending.push_back(4'b0110);
    wait_valid(1);
    step(0, 1, 1);
    for (int k = 0; k < 3; k++) begin
      chk("t3_bp_valid", ser_valid, 1);
      chk("t3_bp_data", ser_data, 1);
      step(0, 1, 0);
    end
    run_idle(50);
    chk("t3_word_count", word_count, 7);

    // reset after 2nd bit of 1100; 0011 then drains cleanly
    pending.push_back(4'b1100);
    pending.push_back(4'b0011);
    wait_valid(1);
    step(0, 1, 1);
    step(0, 1, 1);
    step(1, 1, 1);
    run_idle(50);
    chk("t4_word_count", word_count, 1);

    // enable dropped during word A with B queued
    pending.push_back(4'b1001);
    pending.push_back(4'b0111);
    wait_valid(1);
    r0 = ren_cnt;
    for (int k = 0; k < 10; k++) step(0, 0, 1);
    chk("t5_no_pop_disabled", ren_cnt, r0);
    chk("t5_a_done_wc", word_count, 2);
    chk("t5_idle", busy, 0);
    c0 = cyc;
    step(0, 1, 1);
    run_idle(50);
    chk("t5_b_start", ren_cyc, c0 + 1);
    chk("t5_word_count", word_count, 3);

    // random words, random ready/enable, crosses the 255->0 wrap
    rnd_rdy = 1; rnd_en = 1;
    r0 = ren_cnt;
    for (int w = 0; w < 260; w++) pending.push_back(MW'($urandom));
    run_idle(20000);
    chk("t6_ren_count", ren_cnt - r0, 260);
    chk("t6_word_count_wrap", word_count, 8'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
